// File: rtl/stack_ptr_unit_pkg.sv
// Shared constants for the stack pointer unit: FSM encoding and default stack bases.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stack_ptr_unit_pkg;

    localparam int DEPTH_W = 13;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_FAULT  = 2'd3
    } stk_state_e;

    localparam logic [15:0] MS_BASE_DEF = 16'hFFFF;
    localparam logic [15:0] RS_BASE_DEF = 16'h7FFF;

    // Healthy states are a pure function of occupancy.
    function automatic stk_state_e state_of(input logic [DEPTH_W-1:0] depth,
                                            input logic [DEPTH_W-1:0] max_depth);
        if (depth == '0) begin
            return ST_EMPTY;
        end else if (depth == max_depth) begin
            return ST_FULL;
        end else begin
            return ST_ACTIVE;
        end
    endfunction

endpackage

// File: rtl/stack_ptr_unit_stack_ptr.sv
// One downward-growing stack: pointer, depth counter and EMPTY/ACTIVE/FULL/FAULT FSM.
// Latency: pointer/depth/fault update one clock after the request.
// Backpressure: none; overflow/underflow parks the stack in FAULT until reg_reset_i.
module stack_ptr
    import stack_ptr_unit_pkg::*;
#(
    parameter logic [15:0] BASE  = MS_BASE_DEF,
    parameter int          DEPTH = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pop_i,
    input  logic               write_i,
    input  logic               reg_reset_i,
    output logic [15:0]        ptr_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               fault_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_L = DEPTH_W'(DEPTH);

    logic [15:0]        ptr_q,   ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    stk_state_e         state_q, state_d;

    // Next-state: clear wins, FAULT freezes everything, bad push/pop traps into FAULT.
    always_comb begin
        ptr_d   = ptr_q;
        depth_d = depth_q;
        state_d = state_q;
        if (reg_reset_i) begin
            ptr_d   = BASE;
            depth_d = '0;
            state_d = ST_EMPTY;
        end else if (write_i && (state_q != ST_FAULT)) begin
            if (pop_i) begin
                if (state_q == ST_EMPTY) begin
                    state_d = ST_FAULT;
                end else begin
                    ptr_d   = ptr_q + 16'd1;
                    depth_d = depth_q - DEPTH_W'(1);
                    state_d = state_of(depth_d, DEPTH_L);
                end
            end else begin
                if (state_q == ST_FULL) begin
                    state_d = ST_FAULT;
                end else begin
                    ptr_d   = ptr_q - 16'd1;
                    depth_d = depth_q + DEPTH_W'(1);
                    state_d = state_of(depth_d, DEPTH_L);
                end
            end
        end
    end

    // State register; async reset returns the stack to empty at its base.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= BASE;
            depth_q <= '0;
            state_q <= ST_EMPTY;
        end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            state_q <= state_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign depth_o = depth_q;
    assign fault_o = (state_q == ST_FAULT);

endmodule

// File: rtl/stack_ptr_unit.sv
// Main and return stack pointers with top/second address taps.
// Latency: pointers update one clock after the request; taps are combinational.
// Backpressure: none; each stack traps into a sticky fault on overflow/underflow.
module stack_ptr_unit
    import stack_ptr_unit_pkg::*;
#(
    parameter logic [15:0] MS_BASE = MS_BASE_DEF,
    parameter logic [15:0] RS_BASE = RS_BASE_DEF,
    parameter int          DEPTH   = 256
) (
    input  logic               CLK,
    input  logic               RstN,
    input  logic               MSPop,
    input  logic               MSPWrite,
    input  logic               MSPRegReset,
    input  logic               RSPop,
    input  logic               RSPWrite,
    input  logic               RSPRegReset,
    output logic [15:0]        MSP,
    output logic [15:0]        MSPTop,
    output logic [15:0]        MSPSecond,
    output logic [15:0]        RSP,
    output logic [15:0]        RSPTop,
    output logic [DEPTH_W-1:0] MSDepth,
    output logic [DEPTH_W-1:0] RSDepth,
    output logic               MSFault,
    output logic               RSFault
);

    stack_ptr #(.BASE(MS_BASE), .DEPTH(DEPTH)) u_ms (
        .clk_i       (CLK),
        .rst_ni      (RstN),
        .pop_i       (MSPop),
        .write_i     (MSPWrite),
        .reg_reset_i (MSPRegReset),
        .ptr_o       (MSP),
        .depth_o     (MSDepth),
        .fault_o     (MSFault)
    );

    stack_ptr #(.BASE(RS_BASE), .DEPTH(DEPTH)) u_rs (
        .clk_i       (CLK),
        .rst_ni      (RstN),
        .pop_i       (RSPop),
        .write_i     (RSPWrite),
        .reg_reset_i (RSPRegReset),
        .ptr_o       (RSP),
        .depth_o     (RSDepth),
        .fault_o     (RSFault)
    );

    // Pointer is the free slot; occupied slots sit above it, wrapping mod 2^16.
    assign MSPTop    = MSP + 16'd1;
    assign MSPSecond = MSP + 16'd2;
    assign RSPTop    = RSP + 16'd1;

endmodule

// File: tb/tb_stack_ptr_unit.sv
module tb_stack_ptr_unit;
    import stack_ptr_unit_pkg::*;

    logic CLK  = 1'b0;
    logic RstN = 1'b0;
    always #5 CLK = ~CLK;

    logic MSPop = 0, MSPWrite = 0, MSPRegReset = 0;
    logic RSPop = 0, RSPWrite = 0, RSPRegReset = 0;
    logic [15:0] MSP, MSPTop, MSPSecond, RSP, RSPTop;
    logic [12:0] MSDepth, RSDepth;
    logic        MSFault, RSFault;

    logic d4_RSPop = 0, d4_RSPWrite = 0, d4_RSPRegReset = 0;
    logic [15:0] d4_MSP, d4_MSPTop, d4_MSPSecond, d4_RSP, d4_RSPTop;
    logic [12:0] d4_MSDepth, d4_RSDepth;
    logic        d4_MSFault, d4_RSFault;

    int checks = 0;
    int errors = 0;

    stack_ptr_unit dut (
        .CLK(CLK), .RstN(RstN),
        .MSPop(MSPop), .MSPWrite(MSPWrite), .MSPRegReset(MSPRegReset),
        .RSPop(RSPop), .RSPWrite(RSPWrite), .RSPRegReset(RSPRegReset),
        .MSP(MSP), .MSPTop(MSPTop), .MSPSecond(MSPSecond),
        .RSP(RSP), .RSPTop(RSPTop),
        .MSDepth(MSDepth), .RSDepth(RSDepth),
        .MSFault(MSFault), .RSFault(RSFault)
    );

    stack_ptr_unit #(.DEPTH(4)) dut4 (
        .CLK(CLK), .RstN(RstN),
        .MSPop(1'b0), .MSPWrite(1'b0), .MSPRegReset(1'b0),
        .RSPop(d4_RSPop), .RSPWrite(d4_RSPWrite), .RSPRegReset(d4_RSPRegReset),
        .MSP(d4_MSP), .MSPTop(d4_MSPTop), .MSPSecond(d4_MSPSecond),
        .RSP(d4_RSP), .RSPTop(d4_RSPTop),
        .MSDepth(d4_MSDepth), .RSDepth(d4_RSDepth),
        .MSFault(d4_MSFault), .RSFault(d4_RSFault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, land 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ms_op(input logic pop, input int n);
        for (int i = 0; i < n; i++) begin
            MSPWrite = 1'b1; MSPop = pop;
            step();
        end
        MSPWrite = 1'b0; MSPop = 1'b0;
    endtask

    task automatic rs_op(input logic pop, input int n);
        for (int i = 0; i < n; i++) begin
            RSPWrite = 1'b1; RSPop = pop;
            step();
        end
        RSPWrite = 1'b0; RSPop = 1'b0;
    endtask

    task automatic d4_push(input int n);
        for (int i = 0; i < n; i++) begin
            d4_RSPWrite = 1'b1; d4_RSPop = 1'b0;
            step();
        end
        d4_RSPWrite = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_msp",    32'(MSP),       32'hFFFF);
        check("rst_mstop",  32'(MSPTop),    32'h0000);
        check("rst_ms2nd",  32'(MSPSecond), 32'h0001);
        check("rst_rsp",    32'(RSP),       32'h7FFF);
        check("rst_rstop",  32'(RSPTop),    32'h8000);
        check("rst_msdep",  32'(MSDepth),   32'd0);
        check("rst_rsdep",  32'(RSDepth),   32'd0);
        check("rst_flt",    32'({MSFault, RSFault}), 32'd0);
        check("rst_state",  32'(dut.u_ms.state_q), 32'(ST_EMPTY));
        RstN = 1'b1;

        // Three main pushes
        ms_op(1'b0, 3);
        check("p3_msp",   32'(MSP),       32'hFFFC);
        check("p3_top",   32'(MSPTop),    32'hFFFD);
        check("p3_2nd",   32'(MSPSecond), 32'hFFFE);
        check("p3_dep",   32'(MSDepth),   32'd3);
        check("p3_flt",   32'(MSFault),   32'd0);
        check("p3_rsp",   32'(RSP),       32'h7FFF);

        // Write=0 holds even with Pop=1
        MSPop = 1'b1; step(); MSPop = 1'b0;
        check("hold_msp", 32'(MSP),     32'hFFFC);
        check("hold_dep", 32'(MSDepth), 32'd3);

        // Pop back to empty, then underflow
        ms_op(1'b1, 3);
        check("pop_msp",  32'(MSP),     32'hFFFF);
        check("pop_dep",  32'(MSDepth), 32'd0);
        ms_op(1'b1, 1);
        check("uf_flt",   32'(MSFault), 32'd1);
        check("uf_msp",   32'(MSP),     32'hFFFF);
        check("uf_dep",   32'(MSDepth), 32'd0);
        ms_op(1'b0, 1);
        check("flt_push_msp", 32'(MSP),     32'hFFFF);
        check("flt_push_flt", 32'(MSFault), 32'd1);
        MSPRegReset = 1'b1; step(); MSPRegReset = 1'b0;
        check("clr_flt",  32'(MSFault), 32'd0);
        check("clr_msp",  32'(MSP),     32'hFFFF);

        // Concurrent main push / return pop
        rs_op(1'b0, 2);
        check("rs2_rsp",  32'(RSP),     32'h7FFD);
        check("rs2_top",  32'(RSPTop),  32'h7FFE);
        MSPWrite = 1'b1; MSPop = 1'b0; RSPWrite = 1'b1; RSPop = 1'b1;
        step();
        MSPWrite = 1'b0; RSPWrite = 1'b0; RSPop = 1'b0;
        check("cc_msdep", 32'(MSDepth), 32'd1);
        check("cc_msp",   32'(MSP),     32'hFFFE);
        check("cc_rsdep", 32'(RSDepth), 32'd1);
        check("cc_rsp",   32'(RSP),     32'h7FFE);

        // RegReset wins over Write at depth 5
        ms_op(1'b0, 4);
        check("d5_dep",   32'(MSDepth), 32'd5);
        MSPWrite = 1'b1; MSPRegReset = 1'b1; step();
        MSPWrite = 1'b0; MSPRegReset = 1'b0;
        check("rr_msp",   32'(MSP),     32'hFFFF);
        check("rr_dep",   32'(MSDepth), 32'd0);
        check("rr_rsdep", 32'(RSDepth), 32'd1);

        // DEPTH=4 return stack: fill, FULL, overflow
        d4_push(4);
        check("f_rsp",    32'(d4_RSP),     32'h7FFB);
        check("f_dep",    32'(d4_RSDepth), 32'd4);
        check("f_state",  32'(dut4.u_rs.state_q), 32'(ST_FULL));
        check("f_flt",    32'(d4_RSFault), 32'd0);
        d4_push(1);
        check("of_flt",   32'(d4_RSFault), 32'd1);
        check("of_rsp",   32'(d4_RSP),     32'h7FFB);
        check("of_dep",   32'(d4_RSDepth), 32'd4);
        check("of_ms",    32'(d4_MSDepth), 32'd0);

        // Async reset mid-cycle after two pushes
        MSPRegReset = 1'b1; RSPRegReset = 1'b1; step();
        MSPRegReset = 1'b0; RSPRegReset = 1'b0;
        ms_op(1'b0, 2);
        check("ar_pre",   32'(MSP), 32'hFFFD);
        #2;
        RstN = 1'b0;
        #1;
        check("ar_msp",   32'(MSP),        32'hFFFF);
        check("ar_dep",   32'(MSDepth),    32'd0);
        check("ar_d4flt", 32'(d4_RSFault), 32'd0);
        check("ar_d4rsp", 32'(d4_RSP),     32'h7FFF);
        @(negedge CLK);
        RstN = 1'b1;
        ms_op(1'b0, 1);
        check("rel_msp",  32'(MSP),     32'hFFFE);
        check("rel_dep",  32'(MSDepth), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_ptr_unit.md
STACK_PTR_UNIT -- requirements
Module: stack_ptr_unit

Interface
REQ-001 Parameter MS_BASE, default 16'hFFFF: address of first main-stack slot; the stack grows downward.
REQ-002 Parameter RS_BASE, default 16'h7FFF: address of first return-stack slot; the stack grows downward.
REQ-003 Parameter DEPTH, default 256: maximum entries per stack; legal range 2..4096.
REQ-004 Clocking SHALL be one clock, CLK; reset SHALL be RstN, asynchronous and active-low.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RstN  input  1  asynchronous active-low reset.
REQ-007 MSPop  input  1  main-stack direction when MSPWrite=1: 1 = pop, 0 = push.
REQ-008 MSPWrite  input  1  main-stack pointer update enable.
REQ-009 MSPRegReset  input  1  synchronous main-stack clear.
REQ-010 RSPop  input  1  return-stack direction when RSPWrite=1: 1 = pop, 0 = push.
REQ-011 RSPWrite  input  1  return-stack pointer update enable.
REQ-012 RSPRegReset  input  1  synchronous return-stack clear.
REQ-013 MSP  output  16  next free main-stack slot, which is the push address.
REQ-014 MSPTop  output  16  MSP+1, the top-of-stack address.
REQ-015 MSPSecond  output  16  MSP+2, the second-element address.
REQ-016 RSP  output  16  next free return-stack slot.
REQ-017 RSPTop  output  16  RSP+1.
REQ-018 MSDepth  output  13  main-stack entry count.
REQ-019 RSDepth  output  13  return-stack entry count.
REQ-020 MSFault  output  1  main-stack overflow or underflow, sticky.
REQ-021 RSFault  output  1  return-stack overflow or underflow, sticky.

Function
REQ-022 The main stack and return stack SHALL be identical, independent instances; each rule below applies to both.
REQ-023 Each stack SHALL run an FSM with states EMPTY, ACTIVE, FULL and FAULT.
REQ-024 In EMPTY, ACTIVE or FULL, the state SHALL be a pure function of depth: EMPTY when depth=0, FULL when depth=DEPTH, otherwise ACTIVE.
REQ-025 Push (Write=1, Pop=0) when not FULL: pointer decrements by 1 and depth increments by 1 at the next CLK edge.
REQ-026 Pop (Write=1, Pop=1) when not EMPTY: pointer increments by 1 and depth decrements by 1 at the next CLK edge.
REQ-027 Push in FULL or pop in EMPTY: pointer and depth hold; state goes to FAULT; Fault asserts at the next edge.
REQ-028 In FAULT: pointer and depth hold, all Write requests are ignored, and Fault stays 1.
REQ-029 RegReset=1 SHALL, in any state, set pointer to BASE, depth to 0, Fault to 0 and state to EMPTY at the next edge.
REQ-030 RegReset SHALL have priority over a simultaneous Write.
REQ-031 Write=0 SHALL hold all of that stack's state, regardless of the Pop value.
REQ-032 Top and Second outputs SHALL be combinational from the pointer, with 16-bit modulo wrap and no saturation.
REQ-033 When depth<1, Top is defined but carries no valid data; the same holds for Second when depth<2.
REQ-034 Pointer, depth and Fault SHALL be registered, so outputs change only at a CLK edge or on reset.
REQ-035 Operations on the two stacks in the same cycle SHALL be fully independent.

Reset
REQ-036 While RstN=0: MSP=MS_BASE, RSP=RS_BASE, depths=0, Faults=0, both FSMs in EMPTY.
REQ-037 Reset SHALL act immediately, including in the middle of a cycle or an operation; no partial update survives.
REQ-038 The first update after reset release SHALL occur at the first CLK edge on which RstN=1.

Structure
REQ-039 The FSM state encoding (2-bit) and the default base addresses SHALL be constants in the shared CPU package.
REQ-040 One sub-module, stack_ptr, SHALL implement a single pointer, depth counter and FSM; it is instantiated twice, parameterised by BASE and DEPTH.
REQ-041 The top level SHALL contain only the two instances and the Top/Second adders.

Verification
REQ-042 Reset then 3 main-stack pushes -> MSP=16'hFFFC, MSPTop=16'hFFFD, MSPSecond=16'hFFFE, MSDepth=3, MSFault=0.
REQ-043 Pop with MSDepth=0 -> MSFault=1 next edge, MSP stays 16'hFFFF; a following push is ignored; MSPRegReset clears MSFault.
REQ-044 DEPTH=4: 4 return-stack pushes -> RSP=16'h7FFB, state FULL; a 5th push -> RSFault=1, RSP stays 16'h7FFB.
REQ-045 Main push and return pop in the same cycle (RSDepth=2) -> MSDepth+1 and RSDepth=1, with no cross-effect.
REQ-046 MSPWrite=1 and MSPRegReset=1 together at MSDepth=5 -> MSP=16'hFFFF, MSDepth=0.
REQ-047 RstN driven low between CLK edges after 2 pushes -> outputs return to reset values immediately, without waiting for an edge.
